// File: rtl/wb_stage.sv
// MEM/WB writeback stage: registers the selected result (ALU, aligned load or PC+4)
// and drives the register-file write port plus a matching forwarding tap.
// Optional retired-instruction counter: define WB_INSTRET_COUNTER_EN.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wbInValid,
    input  logic                 wbStall,
    input  logic                 wbFlush,
    input  logic                 wbRegWrite,
    input  logic [NREG_BITS-1:0] wbDest,
    input  logic [1:0]           wbSel,
    input  logic [XLEN-1:0]      aluResult,
    input  logic [XLEN-1:0]      loadWord,
    input  logic [2:0]           loadFunct3,
    input  logic [XLEN-1:0]      pcPlus4,
    output logic                 rgWrtEn,
    output logic [NREG_BITS-1:0] rgWrtDest,
    output logic [XLEN-1:0]      rgWrtData,
    output logic                 fwdValid,
    output logic [NREG_BITS-1:0] fwdDest,
    output logic [XLEN-1:0]      fwdData,
    output logic                 wbErr
`ifdef WB_INSTRET_COUNTER_EN
    ,
    output logic [63:0]          instretCount
`endif
);

    logic [1:0]           offset_s;
    logic [7:0]           byte_s;
    logic [15:0]          half_s;
    logic [XLEN-1:0]      sel_data_s;
    logic                 sel_err_s;

    logic                 valid_q,    valid_d;
    logic                 regwrite_q, regwrite_d;
    logic [NREG_BITS-1:0] dest_q,     dest_d;
    logic [XLEN-1:0]      data_q,     data_d;
    logic                 err_q,      err_d;

    assign offset_s = aluResult[1:0];

    // Extract the addressed byte and halfword from the raw memory word
    always_comb begin
        byte_s = 8'h00;
        case (offset_s)
            2'd0:    byte_s = loadWord[7:0];
            2'd1:    byte_s = loadWord[15:8];
            2'd2:    byte_s = loadWord[23:16];
            default: byte_s = loadWord[31:24];
        endcase
        if (offset_s[1]) begin
            half_s = loadWord[31:16];
        end else begin
            half_s = loadWord[15:0];
        end
    end

    // Write-value select and load extension; misaligned or illegal loads raise err
    always_comb begin
        sel_data_s = {XLEN{1'b0}};
        sel_err_s  = 1'b0;
        case (wbSel)
            2'b00: sel_data_s = aluResult;
            2'b10: sel_data_s = pcPlus4;
            2'b01: begin
                case (loadFunct3)
                    3'b000: sel_data_s = {{(XLEN-8){byte_s[7]}}, byte_s};
                    3'b100: sel_data_s = {{(XLEN-8){1'b0}}, byte_s};
                    3'b001: begin
                        sel_data_s = {{(XLEN-16){half_s[15]}}, half_s};
                        sel_err_s  = offset_s[0];
                    end
                    3'b101: begin
                        sel_data_s = {{(XLEN-16){1'b0}}, half_s};
                        sel_err_s  = offset_s[0];
                    end
                    3'b010: begin
                        sel_data_s = loadWord;
                        sel_err_s  = (offset_s != 2'd0);
                    end
                    default: begin
                        sel_data_s = {XLEN{1'b0}};
                        sel_err_s  = 1'b1;
                    end
                endcase
            end
            default: begin
                sel_data_s = {XLEN{1'b0}};
                sel_err_s  = 1'b1;
            end
        endcase
    end

    // Stage register next state: flush beats stall beats capture
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        dest_d     = dest_q;
        data_d     = data_q;
        err_d      = err_q;
        if (wbFlush) begin
            valid_d = 1'b0;
        end else if (wbStall) begin
            valid_d = valid_q;
        end else begin
            valid_d    = wbInValid;
            regwrite_d = wbRegWrite;
            dest_d     = wbDest;
            data_d     = sel_data_s;
            err_d      = sel_err_s;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            dest_q     <= {NREG_BITS{1'b0}};
            data_q     <= {XLEN{1'b0}};
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // A stalled cycle never writes, so a held instruction writes only once it is released
    assign rgWrtEn   = valid_q & regwrite_q & (dest_q != {NREG_BITS{1'b0}}) & ~err_q & ~wbStall;
    assign rgWrtDest = dest_q;
    assign rgWrtData = data_q;
    assign fwdValid  = rgWrtEn;
    assign fwdDest   = dest_q;
    assign fwdData   = data_q;
    assign wbErr     = valid_q & err_q;

`ifdef WB_INSTRET_COUNTER_EN
    logic [63:0] instret_q;

    // Count every instruction that leaves the stage cleanly, including x0 and no-rd ones
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (valid_q && !wbStall && !err_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instretCount = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// compared against a behavioural model of the stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, wbInValid, wbStall, wbFlush, wbRegWrite;
    logic [4:0]  wbDest;
    logic [1:0]  wbSel;
    logic [31:0] aluResult, loadWord, pcPlus4;
    logic [2:0]  loadFunct3;
    logic        rgWrtEn, fwdValid, wbErr;
    logic [4:0]  rgWrtDest, fwdDest;
    logic [31:0] rgWrtData, fwdData;
`ifdef WB_INSTRET_COUNTER_EN
    logic [63:0] instretCount;
`endif

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .wbInValid(wbInValid), .wbStall(wbStall), .wbFlush(wbFlush),
        .wbRegWrite(wbRegWrite), .wbDest(wbDest), .wbSel(wbSel), .aluResult(aluResult),
        .loadWord(loadWord), .loadFunct3(loadFunct3), .pcPlus4(pcPlus4),
        .rgWrtEn(rgWrtEn), .rgWrtDest(rgWrtDest), .rgWrtData(rgWrtData),
        .fwdValid(fwdValid), .fwdDest(fwdDest), .fwdData(fwdData), .wbErr(wbErr)
`ifdef WB_INSTRET_COUNTER_EN
        , .instretCount(instretCount)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_init = 1'b0;
    bit          m_valid, m_regw, m_err, m_known, m_dknown;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    logic [63:0] m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected write value from the selection rules, using plain shifts and arithmetic
    task automatic ref_wb(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] word, input logic [31:0] pc,
                          output bit err, output logic [31:0] data, output bit dknown);
        int unsigned off, b, h;
        off = alu % 4;
        b = (word >> (8 * off)) % 256;
        h = (word >> (16 * (off / 2))) % 65536;
        err = 1'b0; data = 32'h0; dknown = 1'b1;
        if (sel == 2'd0) data = alu;
        else if (sel == 2'd2) data = pc;
        else if (sel == 2'd3) err = 1'b1;
        else if (f3 == 3'd0) data = (b >= 128) ? (32'(b) + 32'hFFFF_FF00) : 32'(b);
        else if (f3 == 3'd4) data = 32'(b);
        else if (f3 == 3'd1) begin
            data = (h >= 32768) ? (32'(h) + 32'hFFFF_0000) : 32'(h);
            err = (off % 2) != 0;
        end else if (f3 == 3'd5) begin
            data = 32'(h);
            err = (off % 2) != 0;
        end else if (f3 == 3'd2) begin
            data = word;
            err = off != 0;
        end else err = 1'b1;
        if (err && sel == 2'd1 && (f3 == 3'd1 || f3 == 3'd5 || f3 == 3'd2)) dknown = 1'b0;
    endtask

    task automatic model_edge();
        bit e; logic [31:0] d; bit k;
        if (rst) begin
            m_valid = 0; m_regw = 0; m_dest = 5'd0; m_data = 32'd0; m_err = 0;
            m_known = 1; m_dknown = 1; m_cnt = 64'd0; m_init = 1;
        end else begin
            if (m_valid && !wbStall && !m_err) m_cnt = m_cnt + 64'd1;
            if (wbFlush) begin
                m_valid = 0; m_known = 0;
            end else if (!wbStall) begin
                ref_wb(wbSel, loadFunct3, aluResult, loadWord, pcPlus4, e, d, k);
                m_valid = wbInValid; m_regw = wbRegWrite; m_dest = wbDest;
                m_data = d; m_err = e; m_dknown = k; m_known = 1;
            end
        end
    endtask

    task automatic compare_model();
        bit exp_en;
        if (m_init) begin
            exp_en = m_valid && m_regw && (m_dest != 5'd0) && !m_err && !wbStall;
            check_val("m_en", rgWrtEn, exp_en);
            check_val("m_fwdv", fwdValid, exp_en);
            check_val("m_err", wbErr, m_valid && m_err);
            if (m_known) begin
                check_val("m_dest", rgWrtDest, m_dest);
                check_val("m_fdest", fwdDest, m_dest);
                if (m_dknown) begin
                    check_val("m_data", rgWrtData, m_data);
                    check_val("m_fdata", fwdData, m_data);
                end
            end
`ifdef WB_INSTRET_COUNTER_EN
            check_val("m_cnt", instretCount, m_cnt);
`endif
        end
    endtask

    // Starts at posedge+1 with inputs applied; ends at the next posedge+1
    task automatic cycle();
        #3;
        compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic put(input bit v, input bit rw, input logic [4:0] d, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu);
        rst = 0; wbStall = 0; wbFlush = 0;
        wbInValid = v; wbRegWrite = rw; wbDest = d; wbSel = sel; loadFunct3 = f3;
        aluResult = alu; loadWord = 32'h80FF_7F01; pcPlus4 = 32'h0000_0100;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0);
    endtask

    // Capture the applied instruction and check the following cycle against constants
    task automatic dir(input string tag, input logic [4:0] d, input bit en,
                       input logic [31:0] data, input bit err);
        cycle();
        idle();
        #1;
        check_val({tag, "_en"}, rgWrtEn, en);
        check_val({tag, "_err"}, wbErr, err);
        check_val({tag, "_dest"}, rgWrtDest, d);
        if (!err) check_val({tag, "_data"}, rgWrtData, data);
    endtask

    initial begin
        idle();
        rst = 1;
        cycle();

        // Reset held for two cycles while a valid write is presented
        put(1, 1, 5'd5, 2'd0, 3'd0, 32'hDEAD_BEEF);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_val("rst_en", rgWrtEn, 1'b0);
            check_val("rst_data", rgWrtData, 32'd0);
            check_val("rst_err", wbErr, 1'b0);
        end
        idle();
        cycle();
        check_val("rel_en", rgWrtEn, 1'b0);
        check_val("rel_err", wbErr, 1'b0);

        put(1, 1, 5'd3, 2'b00, 3'd0, 32'h1234_5678); dir("alu", 5'd3, 1, 32'h1234_5678, 0);
        put(1, 1, 5'd0, 2'b00, 3'd0, 32'h1234_5678); dir("x0", 5'd0, 0, 32'h1234_5678, 0);
        put(1, 1, 5'd8, 2'b10, 3'd0, 32'h0);         dir("link", 5'd8, 1, 32'h0000_0100, 0);
        put(1, 1, 5'd9, 2'b01, 3'b000, 32'h2);       dir("lb2", 5'd9, 1, 32'hFFFF_FFFF, 0);
        put(1, 1, 5'd9, 2'b01, 3'b100, 32'h3);       dir("lbu3", 5'd9, 1, 32'h0000_0080, 0);
        put(1, 1, 5'd9, 2'b01, 3'b001, 32'h0);       dir("lh0", 5'd9, 1, 32'h0000_7F01, 0);
        put(1, 1, 5'd9, 2'b01, 3'b101, 32'h2);       dir("lhu2", 5'd9, 1, 32'h0000_80FF, 0);
        put(1, 1, 5'd9, 2'b01, 3'b010, 32'h1);       dir("lw1", 5'd9, 0, 32'h0, 1);
        put(1, 1, 5'd9, 2'b01, 3'b011, 32'h0);       dir("f3bad", 5'd9, 0, 32'h0, 1);
        put(1, 0, 5'd0, 2'b11, 3'b000, 32'h0);       dir("sel11", 5'd0, 0, 32'h0, 1);

        // Stall: held for three cycles, then writes exactly once
        put(1, 1, 5'd7, 2'b00, 3'd0, 32'hA);
        cycle();
        put(1, 1, 5'd12, 2'b00, 3'd0, 32'h55);
        wbStall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("stl_en", rgWrtEn, 1'b0);
            check_val("stl_dest", rgWrtDest, 5'd7);
            check_val("stl_data", rgWrtData, 32'hA);
            cycle();
        end
        idle();
        #1;
        check_val("rel_wr", rgWrtEn, 1'b1);
        check_val("rel_data", rgWrtData, 32'hA);
        cycle();
        check_val("rel_once", rgWrtEn, 1'b0);

        // Flush beats stall for an incoming write
        put(1, 1, 5'd4, 2'b00, 3'd0, 32'h44);
        wbFlush = 1; wbStall = 1;
        cycle();
        idle();
        #1;
        check_val("fls_en", rgWrtEn, 1'b0);
        check_val("fls_err", wbErr, 1'b0);
        cycle();

        // Flush discards a held instruction
        put(1, 1, 5'd6, 2'b00, 3'd0, 32'h66);
        cycle();
        wbStall = 1;
        cycle();
        wbFlush = 1;
        cycle();
        idle();
        #1;
        check_val("flh_en", rgWrtEn, 1'b0);
        cycle();

`ifdef WB_INSTRET_COUNTER_EN
        idle(); rst = 1; cycle(); idle();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) put(1, 1, 5'd2, 2'b01, 3'b010, 32'h1);
            else if (i == 5) put(1, 1, 5'd0, 2'b00, 3'd0, 32'(i));
            else put(1, 1, 5'd1, 2'b00, 3'd0, 32'(i));
            cycle();
            if (i == 2 || i == 6) begin
                wbStall = 1;
                cycle();
            end
        end
        idle();
        cycle();
        cycle();
        check_val("cnt9", instretCount, 64'd9);
        rst = 1;
        cycle();
        check_val("cnt_rst", instretCount, 64'd0);
        idle();
        cycle();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom % 60) == 0;
            wbStall    = ($urandom % 4) == 0;
            wbFlush    = ($urandom % 10) == 0;
            wbInValid  = ($urandom % 5) != 0;
            wbRegWrite = ($urandom % 4) != 0;
            wbDest     = 5'($urandom_range(0, 3));
            wbSel      = 2'($urandom % 4);
            loadFunct3 = 3'($urandom % 8);
            aluResult  = $urandom;
            loadWord   = $urandom;
            pcPlus4    = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
